// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor for the RV32I pipeline: PC-indexed saturating counters with a
// selectable policy, EX-stage mispredict detection, recovery PC and saturating statistics.
module branch_predictor_bimodal #(
    parameter int unsigned PC_SIZE    = 12,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CNT_BITS   = 2,
    parameter int unsigned MODE       = 2,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  flush_table,
    output logic                  ready,

    input  logic                  lookup_valid,
    input  logic                  lookup_is_jal,
    input  logic [PC_SIZE-1:0]    lookup_pc,
    input  logic [PC_SIZE-1:0]    lookup_target,
    output logic                  predict_taken,
    output logic [PC_SIZE-1:0]    predict_pc,

    input  logic                  update_valid,
    input  logic [PC_SIZE-1:0]    update_pc,
    input  logic [PC_SIZE-1:0]    update_target,
    input  logic                  update_taken,
    input  logic                  update_predicted,
    output logic                  mispredict,
    output logic [PC_SIZE-1:0]    recover_pc,

    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    localparam logic [CNT_BITS-1:0]   CntInit = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]   CntMax  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]   CntOne  = CNT_BITS'(1);
    localparam logic [PC_SIZE-1:0]    PcStep  = PC_SIZE'(4);
    localparam logic [INDEX_BITS-1:0] IdxLast = {INDEX_BITS{1'b1}};
    localparam logic [STAT_WIDTH-1:0] StatMax = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0] StatOne = STAT_WIDTH'(1);

    localparam logic StInit = 1'b0;
    localparam logic StRun  = 1'b1;

    logic                  state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [STAT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [CNT_BITS-1:0]   table_q [DEPTH];

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic [CNT_BITS-1:0]   lookup_cnt;
    logic [CNT_BITS-1:0]   update_cnt;
    logic [CNT_BITS-1:0]   update_cnt_next;

    logic                  table_we;
    logic [INDEX_BITS-1:0] table_waddr;
    logic [CNT_BITS-1:0]   table_wdata;

    logic                  policy_taken;

    assign ready      = (state_q == StRun);
    assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
    assign update_idx = update_pc[INDEX_BITS+1:2];
    assign lookup_cnt = table_q[lookup_idx];
    assign update_cnt = table_q[update_idx];

    // Lookup path: reads the pre-update table, so same-cycle updates are not visible.
    always_comb begin
        policy_taken = 1'b0;
        if (MODE == 1) begin
            policy_taken = (lookup_target < lookup_pc);
        end else if (MODE == 2) begin
            policy_taken = ready & lookup_cnt[CNT_BITS-1];
        end
    end

    assign predict_taken = lookup_valid & (lookup_is_jal | policy_taken);
    assign predict_pc    = predict_taken ? lookup_target : lookup_pc + PcStep;

    // Resolution path.
    assign mispredict = update_valid & (update_taken != update_predicted);
    assign recover_pc = update_taken ? update_target : update_pc + PcStep;

    always_comb begin
        update_cnt_next = update_cnt;
        if (update_taken) begin
            if (update_cnt != CntMax) begin
                update_cnt_next = update_cnt + CntOne;
            end
        end else if (update_cnt != '0) begin
            update_cnt_next = update_cnt - CntOne;
        end
    end

    // Single write port: the init sweep owns it in INIT, training owns it in RUN.
    always_comb begin
        table_we    = 1'b0;
        table_waddr = update_idx;
        table_wdata = update_cnt_next;
        if (state_q == StInit) begin
            table_we    = 1'b1;
            table_waddr = init_idx_q;
            table_wdata = CntInit;
        end else if ((MODE == 2) && update_valid && !flush_table) begin
            table_we    = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (table_we) begin
            table_q[table_waddr] <= table_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            StInit: begin
                if (flush_table) begin
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + 1'b1;
                    if (init_idx_q == IdxLast) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (flush_table) begin
                    state_d    = StInit;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d    = StInit;
                init_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_valid && (branch_count_q != StatMax)) begin
            branch_count_d = branch_count_q + StatOne;
        end
        if (mispredict && (mispredict_count_q != StatMax)) begin
            mispredict_count_d = mispredict_count_q + StatOne;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q            <= StInit;
            init_idx_q         <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            init_idx_q         <= init_idx_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predictor_bimodal.md
# branch_predictor_bimodal

Parametrised branch-prediction unit for the pipelined RV32I core. It replaces the fixed single-policy jump predictor with a table of saturating counters indexed by PC, and offers three selectable policies. It also detects mispredictions at EX resolution, produces the recovery PC, and keeps saturating performance counters. It sits beside the IF/ID register: the ID stage performs lookups and the EX stage performs updates.

## Interface
- PC_SIZE, 12, PC width in bits (byte address).
- INDEX_BITS, 6, table index width; DEPTH = 2**INDEX_BITS entries.
- CNT_BITS, 2, saturating counter width (≥1).
- MODE, 2, policy: 0 static not-taken, 1 backward-taken/forward-not-taken, 2 bimodal.
- STAT_WIDTH, 32, width of the performance counters.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- flush_table  in  1  one-cycle pulse; re-initialises the table.
- ready  out  1  high when the table is initialised (state RUN).
- lookup_valid  in  1  ID holds a branch or JAL.
- lookup_is_jal  in  1  ID instruction is an unconditional jump.
- lookup_pc  in  PC_SIZE  pc_id.
- lookup_target  in  PC_SIZE  pc_id + imm.
- predict_taken  out  1  combinational prediction.
- predict_pc  out  PC_SIZE  lookup_target if predict_taken, else lookup_pc + 4.
- update_valid  in  1  EX resolves a conditional branch.
- update_pc  in  PC_SIZE  pc_ex.
- update_target  in  PC_SIZE  pc_ex + imm.
- update_taken  in  1  actual outcome.
- update_predicted  in  1  the prediction that was made for this branch, carried down the pipe.
- mispredict  out  1  combinational; flush IF/ID and ID/EX.
- recover_pc  out  PC_SIZE  correct next PC.
- branch_count  out  STAT_WIDTH  resolved conditional branches.
- mispredict_count  out  STAT_WIDTH  mispredictions.

## Operation
- Index is pc[INDEX_BITS+1:2]. There are no tags; aliasing is accepted.
- Counter reset value is 2**(CNT_BITS-1) - 1 (weakly not-taken).
- A counter predicts taken when its MSB is 1.
- Counter update: taken → +1, saturating at 2**CNT_BITS - 1; not taken → -1, saturating at 0.
- predict_taken = lookup_valid & (lookup_is_jal | P), where P depends on MODE:
  - MODE 0: P = 0.
  - MODE 1: P = (lookup_target < lookup_pc), unsigned compare.
  - MODE 2: P = counter MSB, and is forced to 0 when ready = 0.
- mispredict = update_valid & (update_taken != update_predicted).
- recover_pc = update_taken ? update_target : update_pc + 4. All PC adds wrap modulo 2**PC_SIZE.
- Table writes happen only when MODE = 2, state is RUN, update_valid = 1 and flush_table = 0.
- Statistics are counted in every mode and state:
  - branch_count += update_valid.
  - mispredict_count += mispredict.
  - Both saturate at all-ones and never wrap.

FSM:
- States are INIT and RUN, with a sweep index init_idx of INDEX_BITS bits.
- INIT: each cycle writes the reset value to entry init_idx, then init_idx++. The cycle that writes entry DEPTH-1 moves the state to RUN.
- RUN: flush_table = 1 moves to INIT with init_idx = 0 on the next edge.
- flush_table = 1 during INIT restarts the sweep at init_idx = 0.
- RESET forces INIT with init_idx = 0, zeroes both statistics counters, and overrides flush_table.
- flush_table never clears the statistics counters.

## Timing
- Lookup path and mispredict/recover_pc are purely combinational, so the prediction is available in the same cycle.
- Table and statistics updates land on the next rising edge.
- Read-before-write: a lookup and an update to the same index in the same cycle see the pre-update counter.
- After RESET deasserts, ready rises exactly DEPTH cycles later; the same holds after a flush_table pulse.
- Reset values:
  - ready = 0, branch_count = 0, mispredict_count = 0.
  - predict_taken follows the lookup inputs (JAL only while INIT).
  - mispredict and recover_pc follow the update inputs.
- An update arriving while INIT is active is not written to the table but is counted.

## Test plan
- Reset sweep: hold RESET 2 cycles, release with DEPTH = 64 → ready = 0 for 64 cycles, then 1; with lookup_is_jal = 0, predict_taken = 0 throughout.
- Training (MODE = 2): update pc 0x040 taken ×2 → lookup pc 0x040 gives predict_taken = 1. Then 4 not-taken updates → counter saturates at 0 and predict_taken = 0. Aliasing pc 0x140 shares the entry.
- Mispredict: update_taken = 1, update_predicted = 0, update_pc = 0x100, update_target = 0x0F0 → mispredict = 1, recover_pc = 0x0F0. The reversed case gives recover_pc = 0x104; pc 0xFFC wraps to 0x000.
- MODE = 1: lookup_pc = 0x080 with target 0x060 → predict_taken = 1; with target 0x0A0 → 0. JAL → 1 in all modes.
- Same-cycle lookup and update to one index from counter 1 → predict_taken = 0 that cycle and 1 the next.
- STAT_WIDTH = 4: 20 updates with mispredict → both counters hold 15. flush_table mid-run → ready low 64 cycles and counters stay 15; RESET → both counters 0.
